// File: rtl/game_pkg.sv
// Shared definitions for the player-control front end and its consumers.
package game_pkg;

  // Number of slide switches; first_step sizes its inputs from this too.
  localparam int NUM_SW = 4;

  // Default debounce window: 10 ms at 25 MHz, and a counter wide enough to hold it.
  localparam int DEBOUNCE_CYC_DEF = 250000;
  localparam int CNT_W_DEF        = 18;

  // Default select auto-repeat timing: 0.5 s to first repeat, then every 0.2 s.
  localparam int REPEAT_DELAY_DEF  = 12500000;
  localparam int REPEAT_PERIOD_DEF = 5000000;

  // Per-channel debounce FSM encoding.
  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } chan_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser, then a qualify counter that only
// accepts a new level after DEBOUNCE_CYC consecutive cycles of disagreement.
// rise/fall are single-cycle pulses aligned with the level update.
module debounce_channel
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk25MHz,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Synchroniser: straight flop-to-flop, nothing in between.
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Next state: any return to the accepted level before the window closes
  // throws the qualification away; the compare bounds the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sync2_q != level_q) begin
          state_d = QUALIFY;
          cnt_d   = CNT_W'(1);
        end
      end
      QUALIFY: begin
        if (sync2_q == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
          level_d = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, level and pulse registers.
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Player-control front end: debounces NUM_SW switches plus the select button
// in the clk25MHz domain and produces clean levels and event pulses.
// Optional macro SELECT_REPEAT_EN adds auto-repeat pulses while select is held.
module input_conditioner
  import game_pkg::*;
#(
  parameter int NUM_SW        = game_pkg::NUM_SW,
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic              clk25MHz,
  input  logic              rst,
  input  logic [NUM_SW-1:0] switches,
  input  logic              select_button,
  output logic [NUM_SW-1:0] sw_stable,
  output logic [NUM_SW-1:0] sw_change,
  output logic              select_level,
  output logic              select_pulse
);

  localparam int NCH = NUM_SW + 1;  // top channel is the select button

  // Elaboration-time sanity on the timing parameters.
  if (DEBOUNCE_CYC < 2 || (2 ** CNT_W) <= DEBOUNCE_CYC) begin : g_bad_cnt
    $error("input_conditioner: CNT_W too narrow or DEBOUNCE_CYC < 2");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_rep
    $error("input_conditioner: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  logic [NCH-1:0] din, lvl, rise, fall;
  logic           unused_sel_fall;

  assign din = {select_button, switches};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk25MHz (clk25MHz),
      .rst      (rst),
      .din      (din[i]),
      .level    (lvl[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  assign sw_stable       = lvl[NUM_SW-1:0];
  assign sw_change       = rise[NUM_SW-1:0] | fall[NUM_SW-1:0];
  assign select_level    = lvl[NUM_SW];
  assign unused_sel_fall = fall[NUM_SW];  // release never generates a pulse

`ifdef SELECT_REPEAT_EN
  // hold_q counts cycles since the press pulse; it is reloaded after each
  // repeat so the next fire lands REPEAT_PERIOD cycles later.
  localparam int               HOLD_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rep_q, rep_d;

  // Hold counter runs only while the debounced level is high; it is zero in
  // the press cycle, so a repeat can never coincide with the press pulse.
  always_comb begin
    hold_d = hold_q;
    rep_d  = 1'b0;
    if (!lvl[NUM_SW]) begin
      hold_d = '0;
    end else if (hold_q == HOLD_FIRE) begin
      hold_d = HOLD_RELOAD;
      rep_d  = 1'b1;
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Hold counter and repeat pulse registers.
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end

  assign select_pulse = rise[NUM_SW] | rep_q;
`else
  assign select_pulse = rise[NUM_SW];
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a pulse scoreboard: stimulus
// pushes the expected pulse cycle and output values, a negedge monitor pops
// and compares whenever any pulse output is high.
module tb_input_conditioner;

  localparam int NSW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NSW-1:0] switches;
  logic           select_button;
  logic [NSW-1:0] sw_stable, sw_change;
  logic           select_level, select_pulse;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int             c;
    logic [NSW-1:0] chg;
    logic           pls;
    logic [NSW-1:0] stb;
    logic           lvl;
  } exp_t;

  exp_t sbq[$];

  input_conditioner #(
    .NUM_SW        (NSW),
    .DEBOUNCE_CYC  (4),
    .CNT_W         (3),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk25MHz      (clk),
    .rst           (rst),
    .switches      (switches),
    .select_button (select_button),
    .sw_stable     (sw_stable),
    .sw_change     (sw_change),
    .select_level  (select_level),
    .select_pulse  (select_pulse)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [NSW-1:0] chg, input logic pls,
                      input logic [NSW-1:0] stb, input logic lvl);
    exp_t e;
    e.c = c; e.chg = chg; e.pls = pls; e.stb = stb; e.lvl = lvl;
    sbq.push_back(e);
  endtask

  task automatic do_reset(input logic sel);
    switches      = '0;
    select_button = sel;
    rst           = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  // Monitor: every pulse cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (sw_change != '0 || select_pulse) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: cycle %0d chg=%b pls=%b stb=%b lvl=%b",
                 cyc, sw_change, select_pulse, sw_stable, select_level);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (e.c != cyc || e.chg != sw_change || e.pls != select_pulse ||
            e.stb != sw_stable || e.lvl != select_level) begin
          fails++;
          $display("FAIL pulse: got cyc=%0d chg=%b pls=%b stb=%b lvl=%b expected cyc=%0d chg=%b pls=%b stb=%b lvl=%b",
                   cyc, sw_change, select_pulse, sw_stable, select_level,
                   e.c, e.chg, e.pls, e.stb, e.lvl);
        end
      end
    end
  end

  initial begin
    int t0, t1, tf, r;
    switches      = '0;
    select_button = 1'b0;
    rst           = 1'b1;

    // Reset held 3 cycles with inputs low: everything stays zero.
    tick(3);
    chk("rst_sw_stable", int'(sw_stable), 0);
    chk("rst_sw_change", int'(sw_change), 0);
    chk("rst_select",    int'({select_level, select_pulse}), 0);
    rst = 1'b0;
    tick(10);
    chk("post_rst_sw_stable", int'(sw_stable), 0);
    chk("post_rst_select",    int'(select_level), 0);

    // Clean step 0000 -> 0101: one pulse 6 cycles later.
    switches = 4'b0101; t0 = cyc;
    push(t0 + 6, 4'b0101, 1'b0, 4'b0101, 1'b0);
    tick(5);
    chk("step_before_latency", int'(sw_stable), 0);
    tick(5);
    chk("step_sw_stable", int'(sw_stable), 4'b0101);

    // Every bit toggles at once: rises and falls pulse together.
    switches = 4'b1010; t0 = cyc;
    push(t0 + 6, 4'b1111, 1'b0, 4'b1010, 1'b0);
    tick(10);
    chk("toggle_sw_stable", int'(sw_stable), 4'b1010);

    // 3-cycle glitch on bit 0 falls one short of the window: ignored.
    switches = 4'b1011;
    tick(3);
    switches = 4'b1010;
    tick(10);
    chk("glitch_sw_stable", int'(sw_stable), 4'b1010);

    // switch[2] rises, rst hits at cnt=2: no pulse, requalify from scratch.
    do_reset(1'b0);
    tick(2);
    switches = 4'b0100; t0 = cyc;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; t1 = cyc;
    push(t1 + 6, 4'b0100, 1'b0, 4'b0100, 1'b0);
    tick(5);
    chk("midq_before_latency", int'(sw_stable), 0);
    tick(5);
    chk("midq_sw_stable", int'(sw_stable), 4'b0100);

    // Select bounce: 3 high, 1 low, then steady high.
    do_reset(1'b0);
    tick(2);
    select_button = 1'b1;
    tick(3);
    select_button = 1'b0;
    tick(1);
    select_button = 1'b1; tf = cyc;
    push(tf + 6, 4'b0000, 1'b1, 4'b0000, 1'b1);
    r = tf + 30;
`ifdef SELECT_REPEAT_EN
    for (int e = tf + 16; e <= r + 6; e += 3)
      push(e, 4'b0000, 1'b1, 4'b0000, (e >= r + 6) ? 1'b0 : 1'b1);
`endif
    tick(6);
    chk("sel_level_press", int'(select_level), 1);
    tick(r - cyc);
    select_button = 1'b0;
    tick(10);
    chk("sel_level_release", int'(select_level), 0);

    // Select held through reset: reported as a press after release.
    select_button = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0; t1 = cyc;
    push(t1 + 6, 4'b0000, 1'b1, 4'b0000, 1'b1);
    tick(7);
    chk("sel_rst_level", int'(select_level), 1);
    select_button = 1'b0;
    tick(10);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
